// File: rtl/mem_access_driver.sv
// mem_access_driver: processor-side initiator for the byte-wide
// u_request/u_ready memory hierarchy. It takes one load/store command at a
// time, drives it into the hierarchy, and returns a one-cycle response. A
// 256-entry shadow memory checks load data. A saturating counter records
// mismatches and timeouts.
//
// Handshake semantics:
//   cmd:  a command transfers on a rising edge where cmd_valid && cmd_ready.
//         cmd_ready is high only in IDLE while out of reset. A host may hold
//         cmd_valid and its payload until the transfer.
//   u_*:  u_request rises with u_we/u_addr/u_din. All four stay stable until
//         an edge samples u_ready=1, or until the driver times out. u_request
//         then drops for at least one cycle. u_ready is ignored while
//         u_request is low.
//   rsp:  rsp_valid is a one-cycle pulse with no back-pressure.
//         rsp_we/rsp_addr/rsp_data/rsp_mismatch/rsp_timeout are meaningful
//         in that cycle.
module mem_access_driver #(
  parameter int TIMEOUT = 255,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [7:0]       cmd_addr,
  input  logic [7:0]       cmd_data,
  output logic             rsp_valid,
  output logic             rsp_we,
  output logic [7:0]       rsp_addr,
  output logic [7:0]       rsp_data,
  output logic             rsp_mismatch,
  output logic             rsp_timeout,
  output logic [ERR_W-1:0] err_count,
  output logic             u_request,
  output logic             u_we,
  output logic [7:0]       u_addr,
  output logic [7:0]       u_din,
  input  logic             u_ready,
  input  logic [7:0]       u_dout,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Wide enough to hold TIMEOUT-1. It keeps counting harmlessly when the
  // timeout is disabled.
  localparam int TCW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);

  logic [1:0]     state;
  logic [TCW-1:0] tcnt;
  logic [7:0]     shadow [256];
  logic [255:0]   shadow_valid;

  logic done;
  logic timeout_hit;
  logic load_mm;
  logic err_bump;

  // Decode the REQ-state outcome. u_ready has priority over a timeout in the
  // same cycle.
  always_comb begin
    done        = (state == S_REQ) && u_ready;
    timeout_hit = (state == S_REQ) && !u_ready && (TIMEOUT != 0) &&
                  (tcnt == TCW'(TIMEOUT - 1));
    load_mm     = shadow_valid[u_addr] && (u_dout != shadow[u_addr]);
    err_bump    = (done && !u_we && load_mm) || timeout_hit;
    cmd_ready   = rst_n && (state == S_IDLE);
    dbg_state   = state;
  end

  // Main FSM: accept, request, respond, then a one-cycle gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tcnt         <= '0;
      u_request    <= 1'b0;
      u_we         <= 1'b0;
      u_addr       <= 8'h00;
      u_din        <= 8'h00;
      rsp_valid    <= 1'b0;
      rsp_we       <= 1'b0;
      rsp_addr     <= 8'h00;
      rsp_data     <= 8'h00;
      rsp_mismatch <= 1'b0;
      rsp_timeout  <= 1'b0;
      shadow_valid <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            u_we      <= cmd_we;
            u_addr    <= cmd_addr;
            u_din     <= cmd_data;
            u_request <= 1'b1;
            tcnt      <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          tcnt <= tcnt + TCW'(1);
          if (done) begin
            u_request   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_we      <= u_we;
            rsp_addr    <= u_addr;
            rsp_timeout <= 1'b0;
            if (u_we) begin
              rsp_data             <= u_din;
              rsp_mismatch         <= 1'b0;
              shadow_valid[u_addr] <= 1'b1;
            end else begin
              rsp_data     <= u_dout;
              rsp_mismatch <= load_mm;
            end
            state <= S_GAP;
          end else if (timeout_hit) begin
            u_request    <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_we       <= u_we;
            rsp_addr     <= u_addr;
            rsp_data     <= 8'h00;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b1;
            // An abandoned store leaves the location's content unknown.
            if (u_we) shadow_valid[u_addr] <= 1'b0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Shadow data array. It is written only when a store completes. It needs no
  // reset because the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (rst_n && done && u_we) shadow[u_addr] <= u_din;
  end

  // Saturating error counter. It updates at the edge that launches the
  // response, so the new value is visible during the rsp_valid cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_bump && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
